wakeup_ready_array: RTL and testbench
=====================================

// Module: wakeup_ready_array
//
// PURPOSE
//   16-entry issue-queue wakeup/ready tracker.
//   - Holds a source-tag pair and a ready bit per operand for each entry.
//   - Watches the result-tag broadcast bus and sets operand ready bits on a tag match.
//   - Drives readyVec[15:0], one bit per entry that can issue.
//   - Sits directly upstream of the 16-input OR-reduction that produces the
//     queue's "any instruction ready" signal; also supplies the lowest-index pick.
//
// PARAMETERS
//   ENTRIES  16  number of entries; fixed at 16 to match the downstream 16-bit OR reduction
//   TAG_W    6   width of a physical-register / result tag
//
// PORTS
//   clk             in   1      clock; all state changes on the rising edge
//   reset           in   1      synchronous, active-low reset
//   flush           in   1      clear all entries (mispredict recovery)
//   allocValid      in   1      request to write a new entry
//   allocSrcATag    in   TAG_W  source A tag of the new entry
//   allocSrcAReady  in   1      source A already available at allocation
//   allocSrcBTag    in   TAG_W  source B tag of the new entry
//   allocSrcBReady  in   1      source B already available at allocation
//   allocReady      out  1      at least one free entry (~&validVec)
//   allocIdx        out  4      lowest-index free entry; target of this cycle's alloc
//   wakeValid       in   1      result-tag broadcast is valid this cycle
//   wakeTag         in   TAG_W  broadcast result tag
//   issueGrant      in   1      downstream accepts the entry at issueIdx
//   issueIdx        out  4      lowest-index set bit of readyVec; 0 when readyVec==0
//   readyVec        out  16     valid & srcARdy & srcBRdy per entry; feeds the OR reduction
//   validVec        out  16     entry-occupied bits
//
// BEHAVIOUR
//   Reset and outputs
//   - reset==0 at an edge clears all valid and ready bits and all tags.
//   - Outputs after reset: readyVec=0, validVec=0, allocReady=1, allocIdx=0, issueIdx=0.
//   - readyVec and validVec come straight from registers.
//   - allocReady, allocIdx and issueIdx are combinational from registers only.
//   - No comb path exists from any input to any output.
//
//   Allocation
//   - Occurs at the edge when allocValid & allocReady; writes entry allocIdx and sets its valid bit.
//   - allocValid while full (allocReady==0) is ignored; state is unchanged.
//   - Operand ready written = allocSrcXReady | (wakeValid & wakeTag==allocSrcXTag).
//     This is a same-cycle bypass, so a broadcast is never missed.
//
//   Wakeup
//   - On wakeValid, every valid entry with a not-ready operand whose tag == wakeTag sets that ready bit.
//   - Takes effect at the next edge, giving 1-cycle latency to readyVec.
//   - Both operands of one entry may wake on the same broadcast.
//   - Invalid entries are never woken. Tag value 0 is not special.
//
//   Issue
//   - On issueGrant with readyVec!=0, entry issueIdx is freed at the edge:
//     valid and both ready bits are cleared.
//   - issueGrant with readyVec==0 is ignored.
//   - Priority is fixed, lowest index first.
//
//   Simultaneous events
//   - alloc + issue in the same cycle: allocIdx uses the current validVec.
//     The entry freed this cycle is reusable next cycle, never the same cycle.
//     When full, allocReady stays 0 in the issuing cycle.
//   - wake + issue in the same cycle: the issued entry is freed; its wakeup is discarded.
//   - flush overrides alloc, wake and grant: all valid and ready bits are 0 after the edge.
//   - reset overrides flush.
//   - reset mid-operation discards all entries; no partial state survives.
//
// TESTING
//   1. Reset, then alloc A(tag 3, rdy) and B(tag 5, rdy) -> entry 0; next cycle
//      readyVec=16'h0001, validVec=16'h0001, issueIdx=0, allocIdx=1.
//   2. Alloc A=7 not ready, B=9 ready into entry 0; wake tag 7 one cycle later
//      -> readyVec[0]=0 before the wake edge, 1 after.
//   3. Alloc with A=4 not ready while the same cycle wakes tag 4 -> bypass;
//      readyVec bit set one cycle after alloc.
//   4. Fill all 16 entries -> allocReady=0; alloc while full is ignored;
//      grant entry 0 with a same-cycle alloc -> alloc dropped; next cycle
//      allocReady=1, allocIdx=0.
//   5. Entries 2, 5, 9 ready -> issueIdx=2; grant -> issueIdx=5 next cycle;
//      grant with readyVec=0 -> no state change.
//   6. Flush with 10 valid entries, a concurrent alloc and a wake -> validVec=0
//      and readyVec=0 next cycle; reset==0 mid-fill -> all outputs at reset values.

Source files
------------

// File: rtl/wakeup_ready_array_if.sv
// Wakeup/ready tracker bus bundle.
// Groups flush, allocation, wakeup broadcast and issue handshake signals.
//   slave  : the tracker (consumes requests, drives status/pick outputs)
//   master : the issue-queue control logic driving requests
interface wakeup_ready_array_if #(
  parameter int unsigned TAG_W = 6
);
  logic             flush;
  logic             allocValid;
  logic [TAG_W-1:0] allocSrcATag;
  logic             allocSrcAReady;
  logic [TAG_W-1:0] allocSrcBTag;
  logic             allocSrcBReady;
  logic             allocReady;
  logic [3:0]       allocIdx;
  logic             wakeValid;
  logic [TAG_W-1:0] wakeTag;
  logic             issueGrant;
  logic [3:0]       issueIdx;
  logic [15:0]      readyVec;
  logic [15:0]      validVec;

  modport slave (
    input  flush, allocValid, allocSrcATag, allocSrcAReady, allocSrcBTag, allocSrcBReady,
    input  wakeValid, wakeTag, issueGrant,
    output allocReady, allocIdx, issueIdx, readyVec, validVec
  );

  modport master (
    output flush, allocValid, allocSrcATag, allocSrcAReady, allocSrcBTag, allocSrcBReady,
    output wakeValid, wakeTag, issueGrant,
    input  allocReady, allocIdx, issueIdx, readyVec, validVec
  );
endinterface

// File: rtl/wakeup_ready_array.sv
// 16-entry issue-queue wakeup/ready tracker.
// Each entry holds two source tags and a ready bit per operand. A result-tag broadcast sets
// matching ready bits one cycle later; allocation bypasses a same-cycle broadcast. The
// lowest-index free entry is the allocation target and the lowest-index ready entry is the
// issue pick.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : slave side of wakeup_ready_array_if (flush/alloc/wake/issue + status outputs)
module wakeup_ready_array #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 6
) (
  input logic                  clk,
  input logic                  reset,
  wakeup_ready_array_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] rdy_a_q, rdy_a_d;
  logic [ENTRIES-1:0] rdy_b_q, rdy_b_d;
  logic [ENTRIES-1:0] ready_q, ready_d;
  logic [TAG_W-1:0]   tag_a_q [ENTRIES];
  logic [TAG_W-1:0]   tag_a_d [ENTRIES];
  logic [TAG_W-1:0]   tag_b_q [ENTRIES];
  logic [TAG_W-1:0]   tag_b_d [ENTRIES];

  logic [IdxW-1:0] alloc_idx;
  logic [IdxW-1:0] issue_idx;
  logic            alloc_ready;
  logic            alloc_fire;
  logic            issue_fire;
  logic            bypass_a;
  logic            bypass_b;

  function automatic logic [IdxW-1:0] lowest_set(input logic [ENTRIES-1:0] vec);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  // Picks depend only on registered state, so no input reaches an output combinationally.
  always_comb begin
    alloc_ready = ~&valid_q;
    alloc_idx   = lowest_set(~valid_q);
    issue_idx   = lowest_set(ready_q);
    alloc_fire  = bus.allocValid & alloc_ready;
    issue_fire  = bus.issueGrant & (|ready_q);
    bypass_a    = bus.wakeValid & (bus.wakeTag == bus.allocSrcATag);
    bypass_b    = bus.wakeValid & (bus.wakeTag == bus.allocSrcBTag);
  end

  always_comb begin
    valid_d = valid_q;
    rdy_a_d = rdy_a_q;
    rdy_b_d = rdy_b_q;
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    if (bus.flush) begin
      valid_d = '0;
      rdy_a_d = '0;
      rdy_b_d = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.wakeValid && valid_q[i]) begin
          if (tag_a_q[i] == bus.wakeTag) rdy_a_d[i] = 1'b1;
          if (tag_b_q[i] == bus.wakeTag) rdy_b_d[i] = 1'b1;
        end
      end
      // Freeing after the wake loop discards any wakeup of the issued entry.
      if (issue_fire) begin
        valid_d[issue_idx] = 1'b0;
        rdy_a_d[issue_idx] = 1'b0;
        rdy_b_d[issue_idx] = 1'b0;
      end
      // alloc_idx is free in valid_q, so it can never collide with issue_idx.
      if (alloc_fire) begin
        valid_d[alloc_idx] = 1'b1;
        rdy_a_d[alloc_idx] = bus.allocSrcAReady | bypass_a;
        rdy_b_d[alloc_idx] = bus.allocSrcBReady | bypass_b;
        tag_a_d[alloc_idx] = bus.allocSrcATag;
        tag_b_d[alloc_idx] = bus.allocSrcBTag;
      end
    end
    ready_d = valid_d & rdy_a_d & rdy_b_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      rdy_a_q <= '0;
      rdy_b_q <= '0;
      ready_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_a_q[i] <= '0;
        tag_b_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      ready_q <= ready_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_a_q[i] <= tag_a_d[i];
        tag_b_q[i] <= tag_b_d[i];
      end
    end
  end

  assign bus.readyVec   = ready_q;
  assign bus.validVec   = valid_q;
  assign bus.allocReady = alloc_ready;
  assign bus.allocIdx   = alloc_idx;
  assign bus.issueIdx   = issue_idx;

endmodule

// File: tb/tb_wakeup_ready_array.sv
module tb_wakeup_ready_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wakeup_ready_array_if #(.TAG_W(6)) bus ();

  wakeup_ready_array #(.ENTRIES(16), .TAG_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] v;
    logic [15:0] r;
    logic        ar;
    logic [3:0]  ai;
    logic [3:0]  ii;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [15:0] mv, mra, mrb;
  logic [5:0]  mta [16];
  logic [5:0]  mtb [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (x[i]) r = 4'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus, advance the model, push the expected post-edge outputs,
  // then pop and compare after the edge.
  task automatic cycle(input logic av, input logic [5:0] ta, input logic ar,
                       input logic [5:0] tb, input logic br, input logic wv,
                       input logic [5:0] wt, input logic g, input logic fl,
                       input logic rs);
    logic [15:0] rv;
    logic [3:0]  ai, ii;
    logic        doa, doi;
    exp_t        e;
    reset              = rs;
    bus.flush          = fl;
    bus.allocValid     = av;
    bus.allocSrcATag   = ta;
    bus.allocSrcAReady = ar;
    bus.allocSrcBTag   = tb;
    bus.allocSrcBReady = br;
    bus.wakeValid      = wv;
    bus.wakeTag        = wt;
    bus.issueGrant     = g;

    rv  = mv & mra & mrb;
    ai  = lowest(~mv);
    ii  = lowest(rv);
    doa = av & ~(&mv);
    doi = g & (|rv);
    if (!rs) begin
      mv = '0; mra = '0; mrb = '0;
      for (int i = 0; i < 16; i++) begin mta[i] = '0; mtb[i] = '0; end
    end else if (fl) begin
      mv = '0; mra = '0; mrb = '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wv && mv[i] && mta[i] == wt) mra[i] = 1'b1;
        if (wv && mv[i] && mtb[i] == wt) mrb[i] = 1'b1;
      end
      if (doi) begin mv[ii] = 1'b0; mra[ii] = 1'b0; mrb[ii] = 1'b0; end
      if (doa) begin
        mv[ai]  = 1'b1;
        mra[ai] = ar | (wv && wt == ta);
        mrb[ai] = br | (wv && wt == tb);
        mta[ai] = ta;
        mtb[ai] = tb;
      end
    end
    e.v  = mv;
    e.r  = mv & mra & mrb;
    e.ar = ~(&mv);
    e.ai = lowest(~mv);
    e.ii = lowest(mv & mra & mrb);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("validVec",   32'(bus.validVec),   32'(e.v));
    check_eq("readyVec",   32'(bus.readyVec),   32'(e.r));
    check_eq("allocReady", 32'(bus.allocReady), 32'(e.ar));
    check_eq("allocIdx",   32'(bus.allocIdx),   32'(e.ai));
    check_eq("issueIdx",   32'(bus.issueIdx),   32'(e.ii));
  endtask

  task automatic idle();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic alloc(input logic [5:0] ta, input logic ar, input logic [5:0] tb,
                       input logic br);
    cycle(1'b1, ta, ar, tb, br, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic grant();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_flush();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    mv = '0; mra = '0; mrb = '0;
    for (int i = 0; i < 16; i++) begin mta[i] = '0; mtb[i] = '0; end
    @(negedge clk);
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_valid", 32'(bus.validVec),   32'h0);
    check_eq("rst_ready", 32'(bus.readyVec),   32'h0);
    check_eq("rst_aready", 32'(bus.allocReady), 32'h1);

    // Basic allocation, both operands ready
    alloc(6'd3, 1'b1, 6'd5, 1'b1);
    check_eq("t1_ready", 32'(bus.readyVec), 32'h0001);
    check_eq("t1_valid", 32'(bus.validVec), 32'h0001);
    check_eq("t1_aidx",  32'(bus.allocIdx), 32'd1);
    check_eq("t1_iidx",  32'(bus.issueIdx), 32'd0);
    grant();
    check_eq("t1_freed", 32'(bus.validVec), 32'h0);

    // Wakeup with one-cycle latency
    alloc(6'd7, 1'b0, 6'd9, 1'b1);
    check_eq("t2_pre", 32'(bus.readyVec[0]), 32'd0);
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b1);
    check_eq("t2_post", 32'(bus.readyVec[0]), 32'd1);
    grant();

    // Same-cycle bypass on allocation
    cycle(1'b1, 6'd4, 1'b0, 6'd1, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 1'b1);
    check_eq("t3_bypass", 32'(bus.readyVec), 32'h0001);
    grant();

    // Fill, alloc while full, grant with concurrent alloc
    for (int i = 0; i < 16; i++) alloc(6'(i + 10), 1'b1, 6'd2, 1'b1);
    check_eq("t4_full", 32'(bus.allocReady), 32'd0);
    alloc(6'd1, 1'b1, 6'd1, 1'b1);
    check_eq("t4_ignored", 32'(bus.validVec), 32'hFFFF);
    cycle(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
    check_eq("t4_drop",   32'(bus.validVec),   32'hFFFE);
    check_eq("t4_aready", 32'(bus.allocReady), 32'd1);
    check_eq("t4_aidx",   32'(bus.allocIdx),   32'd0);
    do_flush();

    // Priority pick among entries 2, 5, 9
    for (int i = 0; i < 10; i++) alloc(6'd20, (i == 2 || i == 5 || i == 9), 6'd21, 1'b1);
    check_eq("t5_pick2", 32'(bus.issueIdx), 32'd2);
    grant();
    check_eq("t5_pick5", 32'(bus.issueIdx), 32'd5);
    grant();
    grant();
    check_eq("t5_none", 32'(bus.readyVec), 32'h0);
    grant();
    check_eq("t5_noop", 32'(bus.validVec), 32'h01DB);

    // Flush with 10 valid entries, concurrent alloc and wake
    for (int i = 0; i < 3; i++) alloc(6'd30, 1'b0, 6'd31, 1'b1);
    check_eq("t6_ten", 32'(bus.validVec), 32'h03FF);
    cycle(1'b1, 6'd20, 1'b1, 6'd20, 1'b1, 1'b1, 6'd20, 1'b1, 1'b1, 1'b1);
    check_eq("t6_fvalid", 32'(bus.validVec), 32'h0);
    check_eq("t6_fready", 32'(bus.readyVec), 32'h0);

    // Reset mid-fill, also overriding a flush
    for (int i = 0; i < 5; i++) alloc(6'(i), 1'b1, 6'(i), 1'b1);
    cycle(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0);
    check_eq("t6_rvalid", 32'(bus.validVec),   32'h0);
    check_eq("t6_raidx",  32'(bus.allocIdx),   32'd0);
    check_eq("t6_riidx",  32'(bus.issueIdx),   32'd0);

    // Randomised traffic against the model, small tag space for frequent matches
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
